// File: rtl/sar_seq_pkg.sv
// sar_seq_pkg: shared state encoding, default parameters and counter-width helper
// for the SAR conversion sequencer.
package sar_seq_pkg;

   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, ACCUM} state_t;

   localparam int DEF_N_BITS         = 10;
   localparam int DEF_AVG_LOG2       = 2;
   localparam int DEF_SAMPLE_CYCLES  = 4;
   localparam int DEF_TIMEOUT_CYCLES = 64;
   localparam int DEF_FIFO_DEPTH     = 8;

   // bits needed to count 0..n-1, never less than one
   function automatic int cnt_w(input int n);
      return n < 2 ? 1 : $clog2(n);
   endfunction

   localparam int DEF_SAMPLE_W = cnt_w(DEF_SAMPLE_CYCLES);
   localparam int DEF_TIMEOUT_W = cnt_w(DEF_TIMEOUT_CYCLES);
   localparam int DEF_LEVEL_W = cnt_w(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: synchronous result FIFO with a registered head word and an
// occupancy counter one bit wider than the pointers.
module sar_result_fifo
   import sar_seq_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = DEF_N_BITS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [cnt_w(DEPTH):0]    level
);

   localparam int PW = cnt_w(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    rd_next;
   logic             do_push;
   logic             do_pop;

   assign full    = level == LW'(DEPTH);
   assign empty   = level == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_next = rd_ptr + 1'b1;

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;

   // head register follows the word that will be at rd_ptr after this cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdata  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_next;
         level <= level + LW'(do_push) - LW'(do_pop);
         if (do_push && (empty || (do_pop && level == LW'(1))))
            rdata <= wdata;
         else if (do_pop && level > LW'(1))
            rdata <= mem[rd_next];
      end

endmodule

// File: rtl/sar_conversion_sequencer.sv
// sar_conversion_sequencer: drives SAR ADC sample/convert cycles, averages results
// and streams them out through a small FIFO with timeout and overflow flags.
module sar_conversion_sequencer
   import sar_seq_pkg::*;
#(
   parameter int N_BITS         = DEF_N_BITS,
   parameter int AVG_LOG2       = DEF_AVG_LOG2,
   parameter int SAMPLE_CYCLES  = DEF_SAMPLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   input  logic                          clr_flags,
   input  logic                          adc_eoc,
   input  logic [N_BITS-1:0]             adc_result,
   output logic                          adc_hold,
   output logic [N_BITS-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic                          overflow,
   output logic                          timeout_err
);

   localparam int SW  = cnt_w(SAMPLE_CYCLES);
   localparam int TW  = cnt_w(TIMEOUT_CYCLES);
   localparam int AGW = AVG_LOG2 < 1 ? 1 : AVG_LOG2;
   localparam int AW  = N_BITS + AVG_LOG2;

   state_t            state;
   logic [SW-1:0]     s_cnt;
   logic [TW-1:0]     t_cnt;
   logic [AGW-1:0]    a_cnt;
   logic [AW-1:0]     acc;
   logic [AW-1:0]     acc_sum;
   logic [N_BITS-1:0] sample;
   logic [N_BITS-1:0] push_data;
   logic              last;
   logic              push;
   logic              full;
   logic              empty;

   assign acc_sum   = acc + AW'(sample);
   assign push_data = N_BITS'(acc_sum >> AVG_LOG2);
   assign last      = a_cnt == AGW'((1 << AVG_LOG2) - 1);
   assign push      = state == ACCUM && last;
   assign busy      = state != IDLE;
   assign out_valid = !empty;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         adc_hold    <= 1'b0;
         s_cnt       <= '0;
         t_cnt       <= '0;
         a_cnt       <= '0;
         acc         <= '0;
         sample      <= '0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         overflow    <= (overflow && !clr_flags) || (push && full && !out_ready);
         timeout_err <= timeout_err && !clr_flags;
         case (state)
            IDLE: begin
               acc   <= '0;
               a_cnt <= '0;
               s_cnt <= '0;
               if (run) state <= SAMPLE;
            end
            SAMPLE:
               if (s_cnt == SW'(SAMPLE_CYCLES - 1)) begin
                  state    <= CONVERT;
                  adc_hold <= 1'b1;
                  s_cnt    <= '0;
                  t_cnt    <= '0;
               end else
                  s_cnt <= s_cnt + 1'b1;
            CONVERT:
               // first CONVERT cycle may still see the previous conversion's eoc
               if (t_cnt != '0 && adc_eoc) begin
                  sample   <= adc_result;
                  adc_hold <= 1'b0;
                  state    <= ACCUM;
               end else if (t_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  timeout_err <= 1'b1;
                  acc         <= '0;
                  a_cnt       <= '0;
                  adc_hold    <= 1'b0;
                  state       <= run ? SAMPLE : IDLE;
               end else
                  t_cnt <= t_cnt + 1'b1;
            ACCUM: begin
               acc   <= (last || !run) ? '0 : acc_sum;
               a_cnt <= (last || !run) ? '0 : a_cnt + 1'b1;
               state <= run ? SAMPLE : IDLE;
            end
            default: state <= IDLE;
         endcase
      end

   sar_result_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(N_BITS)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .pop  (out_ready),
      .wdata(push_data),
      .rdata(out_data),
      .full (full),
      .empty(empty),
      .level(fifo_level)
   );

endmodule

// File: tb/tb_sar_conversion_sequencer.sv
// tb_sar_conversion_sequencer: directed checks of sequencing, averaging, timeout,
// FIFO overflow/drain and async reset against a simple behavioural ADC.
module tb_sar_conversion_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       a_run, a_clr, a_eoc, a_hold, a_valid, a_ready, a_busy, a_ovf, a_terr;
   logic [9:0] a_res, a_data;
   logic [3:0] a_level;
   logic       b_run, b_clr, b_eoc, b_hold, b_valid, b_ready, b_busy, b_ovf, b_terr;
   logic [9:0] b_res, b_data;
   logic [3:0] b_level;

   sar_conversion_sequencer dut (
      .clk(clk), .reset(reset), .run(a_run), .clr_flags(a_clr), .adc_eoc(a_eoc),
      .adc_result(a_res), .adc_hold(a_hold), .out_data(a_data), .out_valid(a_valid),
      .out_ready(a_ready), .fifo_level(a_level), .busy(a_busy), .overflow(a_ovf),
      .timeout_err(a_terr)
   );

   sar_conversion_sequencer #(.AVG_LOG2(0)) dut_noavg (
      .clk(clk), .reset(reset), .run(b_run), .clr_flags(b_clr), .adc_eoc(b_eoc),
      .adc_result(b_res), .adc_hold(b_hold), .out_data(b_data), .out_valid(b_valid),
      .out_ready(b_ready), .fifo_level(b_level), .busy(b_busy), .overflow(b_ovf),
      .timeout_err(b_terr)
   );

   int n_checks = 0;
   int n_errors = 0;

   // behavioural ADCs: eoc pulses a_dly / 12 cycles after hold rises
   int         a_hc = 0, b_hc = 0, a_dly = 3;
   bit         a_stuck = 1'b0;
   logic [9:0] a_q[$];

   always @(negedge clk) begin
      a_hc  = a_hold ? a_hc + 1 : 0;
      a_eoc = a_stuck || (a_dly != 0 && a_hold && a_hc == a_dly);
      if (a_eoc && !a_stuck && a_q.size() != 0) a_res = a_q.pop_front();
      b_hc  = b_hold ? b_hc + 1 : 0;
      b_eoc = b_hold && b_hc == 12;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_hold(input bit sel, input logic v, output int n);
      n = 0;
      while ((sel ? b_hold : a_hold) !== v) begin
         if (n == 300) begin
            n = -1;
            return;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic conv();
      int n, m;
      wait_hold(1'b0, 1'b1, n);
      wait_hold(1'b0, 1'b0, m);
      check("conv_done", n >= 0 && m >= 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [9:0] v;
      reset = 1'b0;
      {a_run, a_clr, a_ready, b_run, b_clr, b_ready} = '0;
      a_eoc = 1'b0; a_res = '0; b_eoc = 1'b0; b_res = 10'h155;
      repeat (3) @(negedge clk);
      check("rst_hold", a_hold, 0);
      check("rst_valid", a_valid, 0);
      check("rst_data", a_data, 0);
      check("rst_level", a_level, 0);
      check("rst_busy", a_busy, 0);
      check("rst_flags", {a_ovf, a_terr, b_ovf, b_terr, b_busy, b_level}, 0);
      reset = 1'b1;
      @(negedge clk);

      // no averaging: one output per conversion, hold low for sample + accum
      b_run = 1'b1;
      wait_hold(1'b1, 1'b1, n);
      check("b_start", n >= 0, 1);
      wait_hold(1'b1, 1'b0, n);
      check("b_hold_high", n, 12);
      check("b_valid_in_accum", b_valid, 0);
      @(negedge clk);
      check("b_valid", b_valid, 1);
      check("b_data", b_data, 10'h155);
      wait_hold(1'b1, 1'b1, n);
      check("b_hold_low", n + 1, 5);
      b_run = 1'b0;
      b_ready = 1'b1;

      // average of four: 407 >> 2 = 101
      a_q = '{10'd100, 10'd101, 10'd102, 10'd104};
      a_run = 1'b1;
      repeat (4) conv();
      check("avg_none_after3", a_valid, 0);
      a_run = 1'b0;
      @(negedge clk);
      check("avg_valid", a_valid, 1);
      check("avg_data", a_data, 101);
      check("avg_level", a_level, 1);
      check("avg_idle", a_busy, 0);
      a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;
      check("avg_popped", a_valid, 0);

      // timeout: 64 CONVERT cycles, then resample; clear vs set in same cycle
      a_dly = 0;
      a_run = 1'b1;
      wait_hold(1'b0, 1'b1, n);
      check("to_start", n >= 0, 1);
      wait_hold(1'b0, 1'b0, n);
      check("to_high", n, 64);
      check("to_err", a_terr, 1);
      check("to_nopush", a_level, 0);
      check("to_busy", a_busy, 1);
      wait_hold(1'b0, 1'b1, n);
      check("to_resample", n, 4);
      a_run = 1'b0;
      a_clr = 1'b1;
      @(negedge clk);
      check("to_clr", a_terr, 0);
      wait_hold(1'b0, 1'b0, n);
      check("to_setwins", a_terr, 1);
      check("to_idle", a_busy, 0);
      @(negedge clk);
      check("to_clr2", a_terr, 0);
      a_clr = 1'b0;

      // overflow: fill 8, drop 9th, push+pop when full on 10th, then drain
      a_dly = 3;
      for (int g = 0; g < 10; g++) begin
         v = 10'(10 * g + 5);
         repeat (4) a_q.push_back(v);
      end
      a_run = 1'b1;
      for (int g = 0; g < 10; g++) begin
         repeat (4) conv();
         if (g == 8) begin
            check("ovf_full", a_level, 8);
            check("ovf_clear", a_ovf, 0);
         end
         if (g == 9) begin
            check("ovf_level", a_level, 8);
            check("ovf_set", a_ovf, 1);
            check("ovf_head", a_data, 5);
         end
      end
      a_run = 1'b0;
      a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;
      check("full_pushpop_level", a_level, 8);
      check("full_pushpop_head", a_data, 15);
      a_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_data", a_data, i < 7 ? 10 * (i + 1) + 5 : 95);
         @(negedge clk);
      end
      a_ready = 1'b0;
      check("drain_empty", a_valid, 0);
      check("drain_level", a_level, 0);
      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      check("ovf_cleared", a_ovf, 0);

      // run drops during 3rd sample: partial group discarded, restart fresh
      a_q = '{10'd500, 10'd500, 10'd500, 10'd8, 10'd8, 10'd8, 10'd12};
      a_run = 1'b1;
      repeat (2) conv();
      wait_hold(1'b0, 1'b1, n);
      a_run = 1'b0;
      wait_hold(1'b0, 1'b0, n);
      check("stop_inflight", n > 0, 1);
      @(negedge clk);
      check("stop_idle", a_busy, 0);
      check("stop_nopush", a_level, 0);
      a_run = 1'b1;
      repeat (4) conv();
      a_run = 1'b0;
      @(negedge clk);
      check("restart_valid", a_valid, 1);
      check("restart_data", a_data, 9);
      a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;

      // async reset mid-CONVERT with three words queued; stale eoc afterwards
      for (int g = 0; g < 3; g++) repeat (4) a_q.push_back(10'(20 * (g + 1)));
      a_run = 1'b1;
      repeat (12) conv();
      wait_hold(1'b0, 1'b1, n);
      repeat (2) @(negedge clk);
      check("pre_rst_level", a_level, 3);
      check("pre_rst_hold", a_hold, 1);
      reset = 1'b0;
      #1;
      check("arst_hold", a_hold, 0);
      check("arst_valid", a_valid, 0);
      check("arst_level", a_level, 0);
      check("arst_busy", a_busy, 0);
      a_stuck = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      wait_hold(1'b0, 1'b1, n);
      wait_hold(1'b0, 1'b0, n);
      check("stale_eoc_ignored", n, 2);
      a_run = 1'b0;
      a_stuck = 1'b0;
      @(negedge clk);
      check("final_idle", a_busy, 0);
      check("final_level", a_level, 0);
      check("final_terr", a_terr, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
